// File: rtl/viterbi_channel_2a4.sv
// viterbi_channel_2a4: rate-1/2 symbol channel with LFSR-scheduled error injection.
// Define CHANNEL_BURST_EN to widen each error event into a BURST_LEN-symbol burst.
module viterbi_channel_2a4 #(
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int          GUARD_LEN   = 16,
  parameter int          ERR_SPACING = 8,
  parameter int          BURST_LEN   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable_i,
  input  logic [1:0]  enc_data_i,
  input  logic        enc_valid_i,
  output logic [1:0]  chan_data_o,
  output logic        chan_valid_o,
  output logic [1:0]  err_inj,
  output logic [15:0] word_ct,
  output logic [15:0] error_counter
);
  localparam logic [15:0] SEED       = (LFSR_SEED == 16'd0) ? 16'h0001 : LFSR_SEED;
  localparam logic [15:0] GUARD_LAST = 16'(GUARD_LEN - 1);
  localparam logic [7:0]  SPC_LOAD   = 8'(ERR_SPACING - 1);
  localparam logic [1:0]  S_GUARD    = 2'd0;
  localparam logic [1:0]  S_ARMED    = 2'd1;
  logic [15:0] r_lfsr;
  logic [1:0]  r_state;
  logic [7:0]  r_spc;
  logic [15:0] r_gcnt;
  logic [1:0]  r_data;
  logic        r_valid;
  logic [1:0]  r_mask;
  logic [15:0] r_word_ct;
  logic [15:0] r_err_ct;
  logic        w_acc;
  logic        w_fb;
  logic        w_fire;
  logic [1:0]  w_fire_mask;
  logic [1:0]  w_mask;
  logic [1:0]  w_state_n;
  logic [7:0]  w_spc_n;
  logic [15:0] w_gcnt_n;
  logic [16:0] w_err_sum;
  logic [15:0] w_err_n;
  assign w_acc       = enable_i & enc_valid_i;
  assign w_fb        = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_fire      = (r_state == S_ARMED) && (r_spc == 8'd0) && r_lfsr[0];
  assign w_fire_mask = r_lfsr[1] ? 2'b10 : 2'b01;
  assign w_err_sum   = {1'b0, r_err_ct} + 17'(w_mask[0]) + 17'(w_mask[1]);
  assign w_err_n     = w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
`ifdef CHANNEL_BURST_EN
  localparam logic [1:0] S_BURST    = 2'd2;
  localparam logic [3:0] BURST_LOAD = 4'(BURST_LEN - 1);
  logic [3:0] r_bcnt;
  logic [1:0] r_bmask;
  logic [3:0] w_bcnt_n;
  assign w_mask = w_fire ? w_fire_mask : (r_state == S_BURST) ? r_bmask : 2'b00;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bcnt  <= 4'd0;
      r_bmask <= 2'b00;
    end else if (w_acc) begin
      r_bcnt  <= w_bcnt_n;
      r_bmask <= w_fire ? w_fire_mask : r_bmask;
    end
  end
`else
  logic [3:0] w_unused_burst;
  assign w_unused_burst = 4'(BURST_LEN);
  assign w_mask = w_fire ? w_fire_mask : 2'b00;
`endif
  always_comb begin
    w_state_n = r_state;
    w_spc_n   = r_spc;
    w_gcnt_n  = r_gcnt;
`ifdef CHANNEL_BURST_EN
    w_bcnt_n  = r_bcnt;
`endif
    if (r_state == S_GUARD) begin
      w_gcnt_n  = r_gcnt + 16'd1;
      w_state_n = (r_gcnt == GUARD_LAST) ? S_ARMED : S_GUARD;
      w_spc_n   = (r_gcnt == GUARD_LAST) ? SPC_LOAD : r_spc;
    end else if (w_fire) begin
      w_spc_n   = SPC_LOAD;
`ifdef CHANNEL_BURST_EN
      w_state_n = (BURST_LOAD != 4'd0) ? S_BURST : S_ARMED;
      w_bcnt_n  = BURST_LOAD;
`endif
    end else if (r_state == S_ARMED) begin
      w_spc_n = (r_spc == 8'd0) ? 8'd0 : r_spc - 8'd1;
    end
`ifdef CHANNEL_BURST_EN
    if (r_state == S_BURST) begin
      w_bcnt_n  = r_bcnt - 4'd1;
      w_state_n = (r_bcnt == 4'd1) ? S_ARMED : S_BURST;
      w_spc_n   = (r_bcnt == 4'd1) ? SPC_LOAD : r_spc;
    end
`endif
  end
  // Everything except chan_valid_o freezes on cycles with no accepted symbol.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr    <= SEED;
      r_state   <= S_GUARD;
      r_spc     <= 8'd0;
      r_gcnt    <= 16'd0;
      r_data    <= 2'b00;
      r_valid   <= 1'b0;
      r_mask    <= 2'b00;
      r_word_ct <= 16'd0;
      r_err_ct  <= 16'd0;
    end else if (w_acc) begin
      r_lfsr    <= {r_lfsr[14:0], w_fb};
      r_state   <= w_state_n;
      r_spc     <= w_spc_n;
      r_gcnt    <= w_gcnt_n;
      r_data    <= enc_data_i ^ w_mask;
      r_valid   <= 1'b1;
      r_mask    <= w_mask;
      r_word_ct <= r_word_ct + 16'd1;
      r_err_ct  <= w_err_n;
    end else begin
      r_valid   <= 1'b0;
    end
  end
  assign chan_data_o   = r_data;
  assign chan_valid_o  = r_valid;
  assign err_inj       = r_mask;
  assign word_ct       = r_word_ct;
  assign error_counter = r_err_ct;
endmodule

// File: tb/tb_viterbi_channel_2a4.sv
// tb_viterbi_channel_2a4: table vectors plus random traffic checked against an index-based channel model.
module tb_viterbi_channel_2a4;
  localparam int GUARD_LEN   = 16;
  localparam int ERR_SPACING = 8;
`ifdef CHANNEL_BURST_EN
  localparam int BURST_LEN = 3;
`else
  localparam int BURST_LEN = 1;
`endif
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable_i = 1'b0;
  logic        enc_valid_i = 1'b0;
  logic [1:0]  enc_data_i = 2'b00;
  logic [1:0]  chan_data_o;
  logic        chan_valid_o;
  logic [1:0]  err_inj;
  logic [15:0] word_ct;
  logic [15:0] error_counter;
  always #5 clk = ~clk;
  viterbi_channel_2a4 dut (
    .clk(clk), .rst(rst), .enable_i(enable_i), .enc_data_i(enc_data_i), .enc_valid_i(enc_valid_i),
    .chan_data_o(chan_data_o), .chan_valid_o(chan_valid_o), .err_inj(err_inj),
    .word_ct(word_ct), .error_counter(error_counter)
  );
  int n_vec = 0;
  int n_bad = 0;
  logic [15:0] m_lfsr;
  logic [15:0] m_wc;
  int          m_ec, m_n, m_next_ok, m_left;
  logic [1:0]  m_bmask, m_data, m_mask;
  logic        m_valid;
  int          clean, run, events, popsum, min_gap;
  logic [1:0]  cur;
  typedef struct {
    logic        r, en, v;
    logic [1:0]  d;
    logic        valid;
    logic [1:0]  data, err;
    logic [15:0] wc, ec;
  } vec_t;
  vec_t tbl[20];
  task automatic check(input string name, input logic [47:0] got, input logic [47:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask
  task automatic check_ge(input string name, input int got, input int lo);
    n_vec++;
    if (got < lo) begin
      n_bad++;
      $display("FAIL %s: got %0d expected at least %0d at %0t", name, got, lo, $time);
    end
  endtask
  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction
  task automatic model_reset();
    m_lfsr = 16'hACE1; m_wc = 16'd0; m_ec = 0; m_n = 0; m_next_ok = GUARD_LEN + ERR_SPACING;
    m_left = 0; m_bmask = 2'b00; m_data = 2'b00; m_mask = 2'b00; m_valid = 1'b0;
    clean = 0; run = 0; popsum = 0; min_gap = GUARD_LEN + ERR_SPACING - 1;
  endtask
  // Events are scheduled by symbol index: the next one may start no earlier than m_next_ok.
  task automatic model_accept(input logic [1:0] d);
    logic [1:0] mk;
    mk = 2'b00;
    m_n++;
    if (m_left > 0) begin
      mk = m_bmask;
      m_left--;
      if (m_left == 0) m_next_ok = m_n + ERR_SPACING;
    end else if (m_n >= m_next_ok && m_lfsr[0]) begin
      mk = m_lfsr[1] ? 2'b10 : 2'b01;
      m_bmask = mk;
      m_left = BURST_LEN - 1;
      if (m_left == 0) m_next_ok = m_n + ERR_SPACING;
    end
    m_lfsr = lfsr_next(m_lfsr);
    m_wc = m_wc + 16'd1;
    m_ec = (m_ec + $countones(mk) > 65535) ? 65535 : m_ec + $countones(mk);
    m_data = d ^ mk; m_mask = mk; m_valid = 1'b1;
  endtask
  task automatic monitor();
    if (!chan_valid_o) return;
    popsum += $countones(err_inj);
    if (run > 0) begin
      check("burst_mask", 48'(err_inj), 48'(cur));
      run++;
      if (run == BURST_LEN) begin run = 0; clean = 0; end
    end else if (err_inj != 2'b00) begin
      check_ge("spacing", clean, min_gap);
      check("single_bit", 48'($countones(err_inj)), 48'd1);
      events++; cur = err_inj; clean = 0; min_gap = ERR_SPACING - 1;
      run = (BURST_LEN > 1) ? 1 : 0;
    end else clean++;
  endtask
  task automatic step(input logic en, input logic v, input logic [1:0] d, input logic r);
    rst = r; enable_i = en; enc_valid_i = v; enc_data_i = d;
    @(posedge clk);
    if (r) model_reset();
    else if (en && v) model_accept(d);
    else m_valid = 1'b0;
    @(negedge clk);
    if (!r) monitor();
  endtask
  task automatic check_model(input string name);
    check(name, 48'({chan_valid_o, chan_data_o, err_inj, word_ct, error_counter}),
          48'({m_valid, m_data, m_mask, m_wc, 16'(m_ec)}));
  endtask
  initial begin
    int k;
    logic [15:0] wc_hold;
    model_reset();
    events = 0;
    tbl[0] = '{1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 16'd0, 16'd0};
    for (int i = 1; i <= 16; i++) tbl[i] = '{1'b0, 1'b1, 1'b1, 2'b11, 1'b1, 2'b11, 2'b00, 16'(i), 16'd0};
    tbl[17] = '{1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 2'b11, 2'b00, 16'd16, 16'd0};
    tbl[18] = '{1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 2'b11, 2'b00, 16'd16, 16'd0};
    tbl[19] = '{1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 2'b00, 2'b00, 16'd0, 16'd0};
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      step(tbl[i].en, tbl[i].v, tbl[i].d, tbl[i].r);
      check($sformatf("table[%0d]", i), 48'({chan_valid_o, chan_data_o, err_inj, word_ct, error_counter}),
            48'({tbl[i].valid, tbl[i].data, tbl[i].err, tbl[i].wc, tbl[i].ec}));
    end
    for (int i = 0; i < 256; i++) begin
      step(1'b1, 1'b1, 2'($urandom), 1'b0);
      check_model("random_cont");
    end
    check("err_total", 48'(error_counter), 48'(popsum));
    check_ge("events_seen", events, 1);
    for (int i = 0; i < 60; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 2'($urandom), 1'b0);
      check_model("random_gated");
    end
    step(1'b1, 1'b1, 2'($urandom), 1'b0);
    wc_hold = word_ct;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 2'($urandom), 1'b0);
      check_model("stall");
    end
    check("stall_wc", 48'(word_ct), 48'(wc_hold));
    check("stall_lfsr", 48'(dut.r_lfsr), 48'(m_lfsr));
    for (int i = 0; i < 30; i++) begin
      step(1'b1, 1'b1, 2'($urandom), 1'b0);
      check_model("after_stall");
    end
    k = 0;
    do begin
      step(1'b1, 1'b1, 2'($urandom), 1'b0);
      k++;
    end while (m_mask == 2'b00 && k < 300);
    check("event_reached", 48'(m_mask != 2'b00), 48'd1);
    step(1'b1, 1'b1, 2'b11, 1'b1);
    check("rst_outputs", 48'({chan_valid_o, chan_data_o, err_inj, word_ct, error_counter}), 48'd0);
    for (int i = 0; i < 24; i++) begin
      step(1'b1, 1'b1, 2'($urandom), 1'b0);
      check_model("post_rst");
    end
    check("rst_drop", 48'(word_ct), 48'd24);
    step(1'b0, 1'b0, 2'b00, 1'b1);
    force dut.r_err_ct = 16'hFFFE;
    #1 release dut.r_err_ct;
    m_ec = 65534;
    k = 0;
    while (k < 2 && m_n < 500) begin
      step(1'b1, 1'b1, 2'($urandom), 1'b0);
      k += $countones(m_mask);
      check_model("saturate");
    end
    check("sat_hold", 48'(error_counter), 48'hFFFF);
    step(1'b0, 1'b0, 2'b00, 1'b1);
    for (int i = 0; i < 65537; i++) step(1'b1, 1'b1, 2'($urandom), 1'b0);
    check_model("wrap_model");
    check("wrap", 48'(word_ct), 48'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
